// File: rtl/scm_ctrl_pkg.sv
// Shared types and sizes for the SCM row-access controller.
// The state encoding is shared so the controller and any observers agree on it.
package scm_ctrl_pkg;

    localparam int ROW_ADDR_W = 4;
    localparam int NUM_REQ    = 2;
    localparam int HOLD_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RECOVER = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin selector: a lone requester always wins, a tie goes to the pointer.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);

    // One-hot winner selection
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = ptr ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/scm_row_access_arbiter.sv
// Arbitrates two requesters onto one SCM row port and sequences the wordline strobe:
// predecoder settle cycle, HOLD_CYCLES of wl_en, then one recovery cycle.
module scm_row_access_arbiter
    import scm_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [ROW_ADDR_W-1:0] req0_addr,
    input  logic [ROW_ADDR_W-1:0] req1_addr,
    input  logic                  req0_we,
    input  logic                  req1_we,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic                  busy,
    output logic [ROW_ADDR_W-1:0] row_addr,
    output logic                  wl_en,
    output logic                  we
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [1:0]              gnt_q, gnt_d;
    logic [1:0]              done_q, done_d;
    logic                    busy_q, busy_d;
    logic [ROW_ADDR_W-1:0]   row_addr_q, row_addr_d;
    logic                    wl_en_q, wl_en_d;
    logic                    we_q, we_d;
    logic [HOLD_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    ptr_q, ptr_d;
    logic                    owner_q, owner_d;
    logic [1:0]              win_s;

    rr_arbiter_2 u_rr (
        .req (req),
        .ptr (ptr_q),
        .win (win_s)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        gnt_d      = 2'b00;
        done_d     = 2'b00;
        busy_d     = 1'b1;
        row_addr_d = row_addr_q;
        wl_en_d    = 1'b0;
        we_d       = we_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d = SETUP;
                    gnt_d   = win_s;
                    owner_d = win_s[1];
                    ptr_d   = ~win_s[1];
                    if (win_s[1]) begin
                        row_addr_d = req1_addr;
                        we_d       = req1_we;
                    end else begin
                        row_addr_d = req0_addr;
                        we_d       = req0_we;
                    end
                end else begin
                    busy_d = 1'b0;
                    we_d   = 1'b0;
                end
            end
            SETUP: begin
                state_d = STROBE;
                wl_en_d = 1'b1;
                cnt_d   = HOLD_LOAD;
            end
            STROBE: begin
                if (cnt_q == {HOLD_CNT_W{1'b0}}) begin
                    state_d = RECOVER;
                    done_d  = owner_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    wl_en_d = 1'b1;
                end
            end
            RECOVER: begin
                // Leaving the access: we must read 0 for the whole IDLE cycle
                state_d = IDLE;
                busy_d  = 1'b0;
                we_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears wl_en without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            busy_q     <= 1'b0;
            row_addr_q <= {ROW_ADDR_W{1'b0}};
            wl_en_q    <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= {HOLD_CNT_W{1'b0}};
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            row_addr_q <= row_addr_d;
            wl_en_q    <= wl_en_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign row_addr = row_addr_q;
    assign wl_en    = wl_en_q;
    assign we       = we_q;

endmodule

// File: tb/tb_scm_row_access_arbiter.sv
// Directed bench for scm_row_access_arbiter (HOLD_CYCLES=2) with a grant scoreboard.
module tb_scm_row_access_arbiter;

    typedef struct packed {
        logic [1:0] gnt;
        logic [3:0] addr;
        logic       we;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [3:0] req0_addr;
    logic [3:0] req1_addr;
    logic       req0_we;
    logic       req1_we;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [3:0] row_addr;
    logic       wl_en;
    logic       we;

    exp_t exp_q[$];
    exp_t cur;
    int   n_assert;
    int   n_fail;

    scm_row_access_arbiter #(.HOLD_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req0_addr (req0_addr),
        .req1_addr (req1_addr),
        .req0_we   (req0_we),
        .req1_we   (req1_we),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .row_addr  (row_addr),
        .wl_en     (wl_en),
        .we        (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] g, input logic [3:0] a, input logic w);
        exp_t e;
        e.gnt  = g;
        e.addr = a;
        e.we   = w;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One cycle: advance past a rising edge, sample on the falling edge
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},  8'(gnt),      8'd0);
        chk({tag, "_done"}, 8'(done),     8'd0);
        chk({tag, "_busy"}, 8'(busy),     8'd0);
        chk({tag, "_row"},  8'(row_addr), 8'd0);
        chk({tag, "_wl"},   8'(wl_en),    8'd0);
        chk({tag, "_we"},   8'(we),       8'd0);
    endtask

    task automatic wait_grant(input string tag, input int exp_wait);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (gnt == 2'b00 && n < 12);
        chk({tag, "_grant_wait"}, 8'(n), 8'(exp_wait));
        n_assert++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb_underflow observed=grant expected=none", tag);
        end
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = '0;
    endtask

    // Walk one access from @1 to @5, checking the strobe sequence against cur
    task automatic follow(input string tag, input logic drop, input logic late);
        chk({tag, "_gnt@1"},  8'(gnt),      8'(cur.gnt));
        chk({tag, "_row@1"},  8'(row_addr), 8'(cur.addr));
        chk({tag, "_we@1"},   8'(we),       8'(cur.we));
        chk({tag, "_busy@1"}, 8'(busy),     8'd1);
        chk({tag, "_wl@1"},   8'(wl_en),    8'd0);
        if (drop) req = req & ~cur.gnt;
        cyc();
        chk({tag, "_wl@2"},   8'(wl_en),    8'd1);
        chk({tag, "_gnt@2"},  8'(gnt),      8'd0);
        chk({tag, "_row@2"},  8'(row_addr), 8'(cur.addr));
        if (late) begin
            req[1]    = 1'b1;
            req1_addr = 4'hF;
            req1_we   = 1'b0;
            exp_q.push_back(mk(2'b10, 4'hF, 1'b0));
        end
        cyc();
        chk({tag, "_wl@3"},   8'(wl_en),    8'd1);
        chk({tag, "_row@3"},  8'(row_addr), 8'(cur.addr));
        cyc();
        chk({tag, "_wl@4"},   8'(wl_en),    8'd0);
        chk({tag, "_done@4"}, 8'(done),     8'(cur.gnt));
        chk({tag, "_row@4"},  8'(row_addr), 8'(cur.addr));
        chk({tag, "_we@4"},   8'(we),       8'(cur.we));
        chk({tag, "_busy@4"}, 8'(busy),     8'd1);
        cyc();
        chk({tag, "_busy@5"}, 8'(busy),     8'd0);
        chk({tag, "_wl@5"},   8'(wl_en),    8'd0);
        chk({tag, "_we@5"},   8'(we),       8'd0);
        chk({tag, "_done@5"}, 8'(done),     8'd0);
        chk({tag, "_row@5"},  8'(row_addr), 8'(cur.addr));
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req       = 2'b00;
        req0_addr = 4'h0;
        req1_addr = 4'h0;
        req0_we   = 1'b0;
        req1_we   = 1'b0;
        cyc();
        cyc();
        chk_all_zero("reset");
        rst = 1'b0;

        // Single write access to row 0xA
        req0_addr = 4'hA;
        req0_we   = 1'b1;
        req       = 2'b01;
        exp_q.push_back(mk(2'b01, 4'hA, 1'b1));
        wait_grant("single", 1);
        follow("single", 1'b1, 1'b0);

        // Requester 1 arrives mid-access with 0xF; must not disturb the access
        req0_addr = 4'hA;
        req0_we   = 1'b1;
        req1_addr = 4'h0;
        req       = 2'b01;
        exp_q.push_back(mk(2'b01, 4'hA, 1'b1));
        wait_grant("busy0", 1);
        follow("busy0", 1'b1, 1'b1);
        wait_grant("busy1", 1);
        follow("busy1", 1'b1, 1'b0);

        // Contention from reset: pointer starts at requester 0
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req0_addr = 4'h3;
        req0_we   = 1'b1;
        req1_addr = 4'hC;
        req1_we   = 1'b0;
        req       = 2'b11;
        exp_q.push_back(mk(2'b01, 4'h3, 1'b1));
        exp_q.push_back(mk(2'b10, 4'hC, 1'b0));
        exp_q.push_back(mk(2'b01, 4'h3, 1'b1));
        wait_grant("rr0", 1);
        follow("rr0", 1'b0, 1'b0);
        wait_grant("rr1", 1);
        follow("rr1", 1'b0, 1'b0);
        wait_grant("rr2", 1);
        req = 2'b00;
        follow("rr2", 1'b0, 1'b0);

        // Abort: reset during the strobe
        req0_addr = 4'h5;
        req0_we   = 1'b1;
        req       = 2'b01;
        exp_q.push_back(mk(2'b01, 4'h5, 1'b1));
        wait_grant("abort", 1);
        req = 2'b00;
        cyc();
        chk("abort_wl_before", 8'(wl_en), 8'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("abort_async");
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("abort_no_done", 8'(done), 8'd0);
        end
        req1_addr = 4'h0;
        req1_we   = 1'b0;
        req       = 2'b10;
        exp_q.push_back(mk(2'b10, 4'h0, 1'b0));
        wait_grant("post_abort", 1);
        follow("post_abort", 1'b1, 1'b0);

        // Boundary rows, read and write, back-to-back
        req0_addr = 4'h0;
        req0_we   = 1'b0;
        req1_addr = 4'hF;
        req1_we   = 1'b1;
        req       = 2'b11;
        exp_q.push_back(mk(2'b01, 4'h0, 1'b0));
        exp_q.push_back(mk(2'b10, 4'hF, 1'b1));
        wait_grant("bnd0", 1);
        follow("bnd0", 1'b1, 1'b0);
        wait_grant("bnd1", 1);
        follow("bnd1", 1'b1, 1'b0);
        req0_addr = 4'hF;
        req0_we   = 1'b1;
        req1_addr = 4'h0;
        req1_we   = 1'b0;
        req       = 2'b11;
        exp_q.push_back(mk(2'b01, 4'hF, 1'b1));
        exp_q.push_back(mk(2'b10, 4'h0, 1'b0));
        wait_grant("bnd2", 1);
        follow("bnd2", 1'b1, 1'b0);
        wait_grant("bnd3", 1);
        follow("bnd3", 1'b1, 1'b0);

        chk("sb_drained", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/scm_row_access_arbiter.md
SCM_ROW_ACCESS_ARBITER -- requirements
Module: scm_row_access_arbiter

Interface
REQ-001 The block SHALL have one parameter: HOLD_CYCLES, default 2, number of cycles wl_en is high per access (legal 1..8).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: req  input  2  per-requester access request; held until the matching gnt bit.
REQ-006 Port: req0_addr / req1_addr  input  4  row address, all 16 values legal.
REQ-007 Port: req0_we / req1_we  input  1  write (1) or read (0).
REQ-008 Port: gnt  output  2  one-hot, one-cycle accept pulse.
REQ-009 Port: done  output  2  one-hot, one-cycle completion pulse.
REQ-010 Port: busy  output  1  access in flight.
REQ-011 Port: row_addr  output  4  registered row address driven to the 4-to-16 predecoder input.
REQ-012 Port: wl_en  output  1  wordline strobe that gates the predecoded rows.
REQ-013 Port: we  output  1  write enable to the array.

Function
REQ-014 The FSM SHALL have exactly four states, IDLE, SETUP, STROBE and RECOVER, all registered.
REQ-015 In IDLE with any req bit high at a clock edge, the FSM SHALL capture the winner's addr/we into row_addr/we, pulse gnt for the winner, and enter SETUP.
REQ-016 Requests SHALL be sampled only in IDLE; req and addr changes in other states SHALL have no effect.
REQ-017 SETUP SHALL last 1 cycle with wl_en=0 (predecoder settling), then enter STROBE.
REQ-018 STROBE SHALL last HOLD_CYCLES cycles with wl_en=1, using a 3-bit down-counter, then enter RECOVER.
REQ-019 RECOVER SHALL last 1 cycle with wl_en=0, pulse done for the granted requester, then enter IDLE.
REQ-020 Latency from the sampling edge to the done pulse SHALL be HOLD_CYCLES+2 cycles; occupancy per access SHALL be HOLD_CYCLES+3 cycles including the IDLE cycle.
REQ-021 busy SHALL be 1 in SETUP, STROBE and RECOVER, and 0 in IDLE.
REQ-022 row_addr SHALL be stable from SETUP through RECOVER and SHALL hold its last value in IDLE, with no toggling.
REQ-023 we SHALL equal the captured we in SETUP..RECOVER and SHALL be 0 in IDLE.
REQ-024 Arbitration SHALL be round-robin: with a single request, that requester wins; with both requesting, the priority pointer wins.
REQ-025 After each grant, the pointer SHALL move to the other requester.
REQ-026 wl_en and we SHALL never both be high in IDLE, and wl_en SHALL never be high in SETUP or RECOVER.

Reset
REQ-027 rst SHALL asynchronously force state=IDLE, gnt=0, done=0, busy=0, wl_en=0, we=0, row_addr=0, counter=0, pointer=requester 0.
REQ-028 Reset during any state SHALL abandon the in-flight access with no done pulse, and wl_en SHALL fall without waiting for a clock edge.
REQ-029 After rst deasserts, the first edge SHALL be able to sample req normally.

Structure
REQ-030 Package scm_ctrl_pkg SHALL hold the state enum, ROW_ADDR_W=4, NUM_REQ=2 and HOLD_CNT_W=3.
REQ-031 Round-robin selection SHALL be one sub-module, rr_arbiter_2 (inputs req[1:0] and pointer; output one-hot winner), instantiated once.

Verification (HOLD_CYCLES=2, cycles counted from the sampling edge)
REQ-032 Reset: rst=1 mid-run -> all outputs 0 immediately, before any clock edge.
REQ-033 Single access: req=01, addr=0xA, we=1 -> gnt=01 @1; row_addr=0xA and we=1 @1..4; wl_en=1 @2..3; done=01 @4; busy=0 @5.
REQ-034 Contention: req=11 held continuously after reset -> grants in order 01, 10, 01, spaced 5 cycles apart.
REQ-035 Abort: rst pulsed while wl_en=1 -> wl_en drops asynchronously and no done follows; then req=10 with addr=0x0 -> gnt=10 one cycle after sampling, row_addr=0x0.
REQ-036 Ignore while busy: req1 raised @2 with addr=0xF while req0 is in flight -> row_addr stays 0xA through @4, gnt=10 @6, row_addr=0xF @6.
REQ-037 Boundaries: addresses 0x0 and 0xF, read and write, back-to-back -> row_addr and we as captured, with no wl_en overlap between accesses.
